audio_serial_tx: RTL and testbench

AUDIO_SERIAL_TX -- requirements
Module: audio_serial_tx

---
 rtl/audio_serial_tx.sv | 125 ++++++++++++
 tb/tb_audio_serial_tx.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_serial_tx.sv
// audio_serial_tx: stereo I2S serializer. Divides clk down to a bit clock,
// frames 64 bit clocks (32 per channel slot) and shifts out 16-bit
// two's-complement samples MSB first with the I2S one-bit delay. One
// holding register decouples the upstream valid/ready handshake from the
// frame-aligned load of the left/right shift words.
module audio_serial_tx #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] left_in,
    input  logic [15:0] right_in,
    input  logic        sample_valid,
    output logic        sample_ready,
    output logic        serial_clk,
    output logic        lr_clk,
    output logic        serial_out,
    output logic        frame_start,
    output logic        underrun
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [7:0]  div_q,   div_d;
    logic        sclk_q,  sclk_d;
    logic [5:0]  bit_q,   bit_d;
    logic [15:0] shl_q,   shl_d;
    logic [15:0] shr_q,   shr_d;
    logic [15:0] hl_q,    hl_d;
    logic [15:0] hr_q,    hr_d;
    logic        full_q,  full_d;
    logic        fs_q,    fs_d;
    logic        ur_q,    ur_d;

    logic        div_wrap;
    logic        fall;
    logic        load;
    logic        accept;
    logic [4:0]  slot;
    logic [3:0]  idx;
    logic [15:0] word;

    // Events: divider wrap, bit-clock falling toggle, frame load, handshake.
    assign div_wrap = (div_q == DIV_LAST);
    assign fall     = div_wrap & sclk_q;
    assign load     = fall & (bit_q == 6'd63);
    assign accept   = sample_valid & ~full_q;

    // State register; reset clears everything so timing restarts cleanly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q  <= '0;
            sclk_q <= 1'b0;
            bit_q  <= '0;
            shl_q  <= '0;
            shr_q  <= '0;
            hl_q   <= '0;
            hr_q   <= '0;
            full_q <= 1'b0;
            fs_q   <= 1'b0;
            ur_q   <= 1'b0;
        end else begin
            div_q  <= div_d;
            sclk_q <= sclk_d;
            bit_q  <= bit_d;
            shl_q  <= shl_d;
            shr_q  <= shr_d;
            hl_q   <= hl_d;
            hr_q   <= hr_d;
            full_q <= full_d;
            fs_q   <= fs_d;
            ur_q   <= ur_d;
        end
    end

    // Next state: divider, bit counter, frame load and holding-register fill.
    // The load decision uses full_q from the start of the cycle, so a pair
    // accepted in the load cycle itself waits for the following frame.
    always_comb begin
        div_d  = div_wrap ? 8'd0 : div_q + 8'd1;
        sclk_d = div_wrap ? ~sclk_q : sclk_q;
        bit_d  = fall ? bit_q + 6'd1 : bit_q;
        shl_d  = shl_q;
        shr_d  = shr_q;
        hl_d   = hl_q;
        hr_d   = hr_q;
        full_d = full_q;
        fs_d   = load;
        ur_d   = load & ~full_q;
        if (load) begin
            if (full_q) begin
                shl_d  = hl_q;
                shr_d  = hr_q;
                full_d = 1'b0;
            end else begin
                shl_d = '0;
                shr_d = '0;
            end
        end
        if (accept) begin
            hl_d   = left_in;
            hr_d   = right_in;
            full_d = 1'b1;
        end
    end

    // Serial data: slot positions 1..16 carry the sample MSB first; the
    // delay bit at position 0 and the padding at 17..31 are zero.
    always_comb begin
        slot       = bit_q[4:0];
        word       = bit_q[5] ? shr_q : shl_q;
        idx        = 4'(5'd16 - slot);
        serial_out = 1'b0;
        if ((slot >= 5'd1) && (slot <= 5'd16)) begin
            serial_out = word[idx];
        end
    end

    assign sample_ready = ~full_q;
    assign serial_clk   = sclk_q;
    assign lr_clk       = bit_q[5];
    assign frame_start  = fs_q;
    assign underrun     = ur_q;

endmodule

// File: tb/tb_audio_serial_tx.sv
// Testbench for audio_serial_tx: two instances (CLK_DIV 4 and 2) checked
// every cycle against a frame-level behavioural model, plus literal checks.
module tb_audio_serial_tx;

    localparam int CD0 = 4;
    localparam int CD1 = 2;

    logic clk;
    logic rst;
    logic vld0, vld1;
    logic [15:0] l0, r0, l1, r1;
    logic rdy0, sck0, lr0, so0, fs0, ur0;
    logic rdy1, sck1, lr1, so1, fs1, ur1;

    int vecs = 0;
    int errs = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    audio_serial_tx #(.CLK_DIV(CD0)) u0 (
        .clk(clk), .rst(rst), .left_in(l0), .right_in(r0),
        .sample_valid(vld0), .sample_ready(rdy0), .serial_clk(sck0),
        .lr_clk(lr0), .serial_out(so0), .frame_start(fs0), .underrun(ur0)
    );

    audio_serial_tx #(.CLK_DIV(CD1)) u1 (
        .clk(clk), .rst(rst), .left_in(l1), .right_in(r1),
        .sample_valid(vld1), .sample_ready(rdy1), .serial_clk(sck1),
        .lr_clk(lr1), .serial_out(so1), .frame_start(fs1), .underrun(ur1)
    );

    // Behavioural model: time since reset, a one-deep pending pair, and the
    // pair currently on the wire. Outputs are derived arithmetically.
    int          m_t    [2];
    bit          m_full [2];
    logic [15:0] m_hl   [2];
    logic [15:0] m_hr   [2];
    logic [15:0] m_cl   [2];
    logic [15:0] m_cr   [2];
    bit          m_ur   [2];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                m_t[k] = 0; m_full[k] = 0; m_ur[k] = 0;
                m_hl[k] = '0; m_hr[k] = '0; m_cl[k] = '0; m_cr[k] = '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                int cd, tn;
                bit v, acc;
                logic [15:0] il, ir;
                cd = (k == 0) ? CD0 : CD1;
                v  = (k == 0) ? vld0 : vld1;
                il = (k == 0) ? l0 : l1;
                ir = (k == 0) ? r0 : r1;
                tn = m_t[k] + 1;
                acc = v && !m_full[k];
                if (tn % (128 * cd) == 0) begin
                    if (m_full[k]) begin
                        m_cl[k] = m_hl[k]; m_cr[k] = m_hr[k];
                        m_full[k] = 0; m_ur[k] = 0;
                    end else begin
                        m_cl[k] = '0; m_cr[k] = '0; m_ur[k] = 1;
                    end
                end
                if (acc) begin
                    m_hl[k] = il; m_hr[k] = ir; m_full[k] = 1;
                end
                m_t[k] = tn;
            end
        end
    end

    // {ready, serial_clk, lr_clk, serial_out, frame_start, underrun}
    function automatic logic [5:0] model_out(int k);
        int cd, p, tt, b6, b;
        logic [15:0] w;
        logic so, fs;
        cd = (k == 0) ? CD0 : CD1;
        p  = 128 * cd;
        tt = m_t[k];
        b6 = (tt / (2 * cd)) % 64;
        b  = b6 % 32;
        w  = (b6 >= 32) ? m_cr[k] : m_cl[k];
        so = (b >= 1 && b <= 16) ? w[16 - b] : 1'b0;
        fs = (tt > 0) && (tt % p == 0);
        return {!m_full[k], ((tt / cd) % 2) == 1, b6 >= 32, so, fs, fs && m_ur[k]};
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            if (errs <= 40)
                $display("FAIL %s @%0t: got %0h, want %0h", name, $time, act, exp);
        end
    endtask

    task automatic compare_all();
        logic [5:0] a0, a1, e0, e1;
        a0 = {rdy0, sck0, lr0, so0, fs0, ur0};
        a1 = {rdy1, sck1, lr1, so1, fs1, ur1};
        e0 = model_out(0);
        e1 = model_out(1);
        chk("u0.ready", a0[5], e0[5]); chk("u0.sclk", a0[4], e0[4]);
        chk("u0.lr",    a0[3], e0[3]); chk("u0.sout", a0[2], e0[2]);
        chk("u0.fs",    a0[1], e0[1]); chk("u0.ur",   a0[0], e0[0]);
        chk("u1.ready", a1[5], e1[5]); chk("u1.sclk", a1[4], e1[4]);
        chk("u1.lr",    a1[3], e1[3]); chk("u1.sout", a1[2], e1[2]);
        chk("u1.fs",    a1[1], e1[1]); chk("u1.ur",   a1[0], e1[0]);
    endtask

    task automatic tick();
        @(negedge clk);
        compare_all();
    endtask

    task automatic wait_fs0(input int max, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!fs0 && n < max);
        if (fs0 !== 1'b1) chk("fs_timeout", 64'(fs0), 64'd1);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Instance 1 sees free-running random traffic for the whole run.
    initial begin
        vld1 = 1'b0; l1 = '0; r1 = '0;
        forever begin
            @(negedge clk);
            vld1 = ($urandom_range(0, 2) == 0);
            l1   = 16'($urandom);
            r1   = 16'($urandom);
        end
    end

    initial begin
        int n, acc_cnt;
        bit seen_fs, prev_rdy;
        logic [63:0] bits;
        logic [15:0] pat, lbits;

        rst = 1'b0; vld0 = 1'b0; l0 = '0; r0 = '0;
        #2;
        chk("rst_ready", 64'(rdy0), 64'd1);
        chk("rst_sclk",  64'(sck0), 64'd0);
        chk("rst_sout",  64'(so0),  64'd0);
        chk("rst_fs",    64'(fs0),  64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Idle after reset: divider, slot and first-underrun timing.
        repeat (3) tick();
        chk("sclk0_t3", 64'(sck0), 64'd0);
        chk("sclk1_t3", 64'(sck1), 64'd1);
        tick();
        chk("sclk0_t4", 64'(sck0), 64'd1);
        chk("sclk1_t4", 64'(sck1), 64'd0);
        repeat (251) tick();
        chk("lr_t255", 64'(lr0), 64'd0);
        tick();
        chk("lr_t256", 64'(lr0), 64'd1);
        repeat (255) tick();
        chk("fs_t511", 64'(fs0), 64'd0);
        tick();
        chk("fs_t512", 64'(fs0), 64'd1);
        chk("ur_t512", 64'(ur0), 64'd1);

        // Known pair accepted in frame 0 appears in frame 1.
        apply_reset();
        vld0 = 1'b1; l0 = 16'hA5C3; r0 = 16'h8001;
        tick();
        vld0 = 1'b0;
        chk("ready_after_acc", 64'(rdy0), 64'd0);
        wait_fs0(600, n);
        chk("frame1_delay", 64'(n), 64'd511);
        chk("frame1_ur", 64'(ur0), 64'd0);
        bits[63] = so0;
        for (int i = 1; i < 64; i++) begin
            repeat (2 * CD0) tick();
            bits[63 - i] = so0;
        end
        chk("frame1_bits", bits, {32'h52E18000, 32'h40008000});

        // Continuous valid with an incrementing pattern.
        pat = 16'h0100; l0 = pat; r0 = ~pat; vld0 = 1'b1;
        prev_rdy = rdy0; acc_cnt = 0; seen_fs = 0;
        for (int i = 0; i < 4 * 128 * CD0; i++) begin
            tick();
            if (prev_rdy) begin
                acc_cnt++;
                pat = pat + 16'd1; l0 = pat; r0 = ~pat;
            end
            if (fs0) begin
                if (seen_fs) chk("one_acc_per_frame", 64'(acc_cnt), 64'd1);
                seen_fs = 1; acc_cnt = 0;
            end
            prev_rdy = rdy0;
        end
        vld0 = 1'b0;

        // Valid offered exactly in the load cycle with holding empty.
        wait_fs0(600, n);
        repeat (128 * CD0 - 1) tick();
        vld0 = 1'b1; l0 = 16'h1234; r0 = 16'hFEDC;
        tick();
        vld0 = 1'b0;
        chk("lc_fs", 64'(fs0), 64'd1);
        chk("lc_ur", 64'(ur0), 64'd1);
        chk("lc_ready", 64'(rdy0), 64'd0);
        wait_fs0(600, n);
        chk("lc_next_ur", 64'(ur0), 64'd0);
        for (int i = 0; i < 16; i++) begin
            repeat (2 * CD0) tick();
            lbits[15 - i] = so0;
        end
        chk("lc_left", 64'(lbits), 64'h1234);

        // Reset mid-frame with holding full discards everything.
        vld0 = 1'b1; l0 = 16'hBEEF; r0 = 16'hCAFE;
        tick();
        vld0 = 1'b0;
        repeat (24 * 2 * CD0) tick();
        chk("pre_rst_ready", 64'(rdy0), 64'd0);
        chk("pre_rst_lr", 64'(lr0), 64'd1);
        #2 rst = 1'b0;
        #1;
        chk("midrst_ready", 64'(rdy0), 64'd1);
        chk("midrst_sclk",  64'(sck0), 64'd0);
        chk("midrst_lr",    64'(lr0),  64'd0);
        chk("midrst_sout",  64'(so0),  64'd0);
        chk("midrst_fs",    64'(fs0),  64'd0);
        chk("midrst_ur",    64'(ur0),  64'd0);
        @(negedge clk);
        rst = 1'b1;
        wait_fs0(600, n);
        chk("restart_delay", 64'(n), 64'd512);
        chk("stale_lost_ur", 64'(ur0), 64'd1);

        // Random traffic on instance 0.
        for (int i = 0; i < 3 * 128 * CD0; i++) begin
            vld0 = ($urandom_range(0, 3) == 0);
            l0 = 16'($urandom);
            r0 = 16'($urandom);
            tick();
        end
        vld0 = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
